// File: rtl/fp_sqrt_ieee.sv
// ---------------------------------------------------------------------------
// fp_sqrt_ieee
//   Iterative IEEE-754 square root. A radix-2 restoring digit recurrence
//   produces one root bit per cycle. The result is rounded to nearest-even.
//   Special operands (zeros, infinities, NaNs, negatives) are resolved in
//   UNPACK but still run the full schedule, so latency never depends on
//   the operand: done rises MAN_W+3 cycles after the start edge.
//
//   Optional feature macro: FP_SQRT_SUBNORMAL_EN
//     defined   : subnormal inputs are normalised with a leading-zero count
//     undefined : subnormal inputs are flushed to a zero of the same sign
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   1-cycle pulse, op sampled on this edge (restarts if busy)
//   done       out  high when idle; res/flags valid
//   op         in   operand, DATA_W bits
//   res        out  result, DATA_W bits
//   overflow   out  always 0 (sqrt cannot overflow)
//   underflow  out  always 0 (sqrt cannot underflow)
//   exception  out  invalid operation (negative non-zero, -inf, sNaN)
//   inexact    out  rounded result differs from the exact root
// ---------------------------------------------------------------------------
module fp_sqrt_ieee #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              done,
    input  logic [DATA_W-1:0] op,
    output logic [DATA_W-1:0] res,
    output logic              overflow,
    output logic              underflow,
    output logic              exception,
    output logic              inexact
);

    localparam int MAN_W  = DATA_W - EXP_W;    // significand incl. hidden bit
    localparam int FRAC_W = MAN_W - 1;
    localparam int Q_W    = MAN_W + 1;         // root bits plus guard
    localparam int RAD_W  = 2 * Q_W;
    localparam int REM_W  = MAN_W + 3;
    localparam int E_W    = EXP_W + 1;         // signed unbiased exponent
    localparam int CNT_W  = $clog2(Q_W);
    localparam int BIAS   = 2**(EXP_W-1) - 1;

    localparam logic signed [E_W-1:0] BIAS_S   = E_W'(BIAS);
    localparam logic [EXP_W-1:0]      BIAS_U   = EXP_W'(BIAS);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MAN_W);
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNPACK = 2'd1,
        ST_ITER   = 2'd2,
        ST_ROUND  = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [DATA_W-1:0]    op_r;
    logic [RAD_W-1:0]     rad_r;
    logic [REM_W-1:0]     rem_r;
    logic [Q_W-1:0]       q_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [EXP_W-1:0]     exp_r;
    logic                 special_r;
    logic [DATA_W-1:0]    spec_res_r;
    logic                 spec_exc_r;
    logic [DATA_W-1:0]    res_r;
    logic                 done_r;
    logic                 exception_r;
    logic                 inexact_r;

    // Operand fields
    logic                 sign_s;
    logic [EXP_W-1:0]     bexp_s;
    logic [FRAC_W-1:0]    frac_s;
    logic                 exp_max_s, exp_zero_s, frac_zero_s;
    logic [MAN_W-1:0]     sig_s, sig_n_s;
    logic signed [E_W-1:0] e_s;
    logic [RAD_W-1:0]     rad_s;
    logic [EXP_W-1:0]     rexp_s;
    logic                 spec_s, spec_exc_s;
    logic [DATA_W-1:0]    spec_res_s;

    // Recurrence and rounding
    logic [1:0]           pair_s;
    logic [REM_W+1:0]     tmp_s, trial_s;
    logic                 ge_s;
    logic [REM_W-1:0]     rem_nxt_s;
    logic [Q_W-1:0]       q_nxt_s;
    logic                 guard_s, sticky_s, up_s, carry_s;
    logic [FRAC_W-1:0]    frac_rnd_s;
    logic [DATA_W-1:0]    norm_res_s;

`ifdef FP_SQRT_SUBNORMAL_EN
    localparam int LZC_W = $clog2(MAN_W);
    localparam logic [LZC_W-1:0]      LZC_ONE = {{(LZC_W-1){1'b0}}, 1'b1};
    localparam logic signed [E_W-1:0] ONE_S   = {{(E_W-1){1'b0}}, 1'b1};

    logic [LZC_W-1:0] lzc_s;

    // Leading-zero count of a non-zero significand
    function automatic logic [LZC_W-1:0] lzc_f(input logic [MAN_W-1:0] v);
        logic found;
        lzc_f = {LZC_W{1'b0}};
        found = 1'b0;
        for (int i = MAN_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    lzc_f = lzc_f + LZC_ONE;
                end
            end
        end
    endfunction
`endif

    assign sign_s      = op_r[DATA_W-1];
    assign bexp_s      = op_r[DATA_W-2 -: EXP_W];
    assign frac_s      = op_r[FRAC_W-1:0];
    assign exp_max_s   = &bexp_s;
    assign exp_zero_s  = (bexp_s == {EXP_W{1'b0}});
    assign frac_zero_s = (frac_s == {FRAC_W{1'b0}});
    assign sig_s       = {~exp_zero_s, frac_s};

    // Normalise the significand and form the unbiased exponent
    always_comb begin
`ifdef FP_SQRT_SUBNORMAL_EN
        lzc_s = lzc_f(sig_s);
        if (exp_zero_s) begin
            sig_n_s = sig_s << lzc_s;
            e_s     = ONE_S - BIAS_S - $signed({{(E_W-LZC_W){1'b0}}, lzc_s});
        end else begin
            sig_n_s = sig_s;
            e_s     = $signed({1'b0, bexp_s}) - BIAS_S;
        end
`else
        sig_n_s = sig_s;
        e_s     = $signed({1'b0, bexp_s}) - BIAS_S;
`endif
    end

    // An odd exponent moves one factor of two into the radicand. The result
    // exponent uses e[EXP_W:1], which equals floor(e/2) in modular form.
    always_comb begin
        if (e_s[0]) begin
            rad_s = {sig_n_s, {(MAN_W+2){1'b0}}};
        end else begin
            rad_s = {1'b0, sig_n_s, {(MAN_W+1){1'b0}}};
        end
        rexp_s = BIAS_U + e_s[EXP_W:1];
    end

    // Special operand classification. NaN first, then zeros, then negatives.
    always_comb begin
        spec_s     = 1'b0;
        spec_exc_s = 1'b0;
        spec_res_s = {DATA_W{1'b0}};
        if (exp_max_s) begin
            spec_s = 1'b1;
            if (frac_zero_s) begin
                if (sign_s) begin
                    spec_res_s = QNAN;
                    spec_exc_s = 1'b1;
                end else begin
                    spec_res_s = op_r;
                end
            end else begin
                spec_res_s = QNAN;
                spec_exc_s = ~frac_s[FRAC_W-1];
            end
        end else if (exp_zero_s && frac_zero_s) begin
            spec_s     = 1'b1;
            spec_res_s = op_r;
`ifndef FP_SQRT_SUBNORMAL_EN
        end else if (exp_zero_s) begin
            // Flush-to-zero keeps the sign and raises nothing
            spec_s     = 1'b1;
            spec_res_s = {sign_s, {(DATA_W-1){1'b0}}};
`endif
        end else if (sign_s) begin
            spec_s     = 1'b1;
            spec_res_s = QNAN;
            spec_exc_s = 1'b1;
        end else begin
            spec_s     = 1'b0;
        end
    end

    // One restoring step: bring down two radicand bits, try root*4+1
    always_comb begin
        pair_s    = rad_r[RAD_W-1 -: 2];
        tmp_s     = {rem_r, pair_s};
        trial_s   = {2'b00, q_r, 2'b01};
        ge_s      = (tmp_s >= trial_s);
        if (ge_s) begin
            rem_nxt_s = REM_W'(tmp_s - trial_s);
        end else begin
            rem_nxt_s = tmp_s[REM_W-1:0];
        end
        q_nxt_s   = {q_r[Q_W-2:0], ge_s};
    end

    // Round to nearest-even; a fraction carry-out wraps frac to zero and
    // bumps the exponent, which is the significand carry-out case.
    always_comb begin
        guard_s  = q_r[0];
        sticky_s = |rem_r;
        up_s     = guard_s & (sticky_s | q_r[1]);
        {carry_s, frac_rnd_s} = {1'b0, q_r[FRAC_W:1]} + {{FRAC_W{1'b0}}, up_s};
        norm_res_s = {1'b0, exp_r + {{(EXP_W-1){1'b0}}, carry_s}, frac_rnd_s};
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; start always (re)launches an operation
    always_comb begin
        state_s = state_r;
        if (start) begin
            state_s = ST_UNPACK;
        end else begin
            case (state_r)
                ST_IDLE:   state_s = ST_IDLE;
                ST_UNPACK: state_s = ST_ITER;
                ST_ITER:   state_s = (cnt_r == CNT_LAST) ? ST_ROUND : ST_ITER;
                ST_ROUND:  state_s = ST_IDLE;
                default:   state_s = ST_IDLE;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r        <= {DATA_W{1'b0}};
            rad_r       <= {RAD_W{1'b0}};
            rem_r       <= {REM_W{1'b0}};
            q_r         <= {Q_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            exp_r       <= {EXP_W{1'b0}};
            special_r   <= 1'b0;
            spec_res_r  <= {DATA_W{1'b0}};
            spec_exc_r  <= 1'b0;
            res_r       <= {DATA_W{1'b0}};
            done_r      <= 1'b1;
            exception_r <= 1'b0;
            inexact_r   <= 1'b0;
        end else if (start) begin
            op_r   <= op;
            done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_UNPACK: begin
                    rad_r      <= rad_s;
                    rem_r      <= {REM_W{1'b0}};
                    q_r        <= {Q_W{1'b0}};
                    cnt_r      <= {CNT_W{1'b0}};
                    exp_r      <= rexp_s;
                    special_r  <= spec_s;
                    spec_res_r <= spec_res_s;
                    spec_exc_r <= spec_exc_s;
                end
                ST_ITER: begin
                    rad_r <= {rad_r[RAD_W-3:0], 2'b00};
                    rem_r <= rem_nxt_s;
                    q_r   <= q_nxt_s;
                    cnt_r <= cnt_r + CNT_ONE;
                end
                ST_ROUND: begin
                    done_r <= 1'b1;
                    if (special_r) begin
                        res_r       <= spec_res_r;
                        exception_r <= spec_exc_r;
                        inexact_r   <= 1'b0;
                    end else begin
                        res_r       <= norm_res_s;
                        exception_r <= 1'b0;
                        inexact_r   <= guard_s | sticky_s;
                    end
                end
                default: begin
                    done_r <= done_r;
                end
            endcase
        end
    end

    assign done      = done_r;
    assign res       = res_r;
    assign exception = exception_r;
    assign inexact   = inexact_r;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;

endmodule

// File: tb/tb_fp_sqrt_ieee.sv
module tb_fp_sqrt_ieee;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        done;
    logic [31:0] op;
    logic [31:0] res;
    logic        overflow;
    logic        underflow;
    logic        exception;
    logic        inexact;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    fp_sqrt_ieee #(.DATA_W(32), .EXP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .done      (done),
        .op        (op),
        .res       (res),
        .overflow  (overflow),
        .underflow (underflow),
        .exception (exception),
        .inexact   (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic longint isqrt(input longint r);
        longint s;
        s = longint'($sqrt(real'(r)));
        while (s * s > r) s--;
        while ((s + 1) * (s + 1) <= r) s++;
        return s;
    endfunction

    // Reference: {exception, inexact, result} from the IEEE definition
    function automatic logic [33:0] ref_sqrt(input logic [31:0] x);
        logic        sgn;
        int          ex;
        longint      f, m, r, s, mant;
        int          e, rexp;
        bit          guard, sticky, up;
        logic [31:0] rv;
        sgn = x[31];
        ex  = int'(x[30:23]);
        f   = longint'(x[22:0]);
        if (ex == 255) begin
            if (f == 0) return sgn ? {1'b1, 1'b0, QNAN} : {1'b0, 1'b0, x};
            return {~x[22], 1'b0, QNAN};
        end
        if (ex == 0 && f == 0) return {2'b00, x};
`ifndef FP_SQRT_SUBNORMAL_EN
        if (ex == 0) return {2'b00, sgn, 31'd0};
`endif
        if (sgn) return {1'b1, 1'b0, QNAN};
        if (ex == 0) begin
            m = f;
            e = -126;
            while (m < (64'sd1 <<< 23)) begin
                m = m <<< 1;
                e--;
            end
        end else begin
            m = f + (64'sd1 <<< 23);
            e = ex - 127;
        end
        if ((e & 1) != 0) begin
            m = m <<< 1;
            e = e - 1;
        end
        rexp   = 127 + e / 2;
        r      = m <<< 25;
        s      = isqrt(r);
        guard  = (s % 2) == 1;
        sticky = (s * s) != r;
        mant   = s / 2;
        up     = guard && (sticky || (mant % 2) == 1);
        if (up) mant = mant + 1;
        if (mant == (64'sd1 <<< 24)) begin
            mant = 64'sd1 <<< 23;
            rexp = rexp + 1;
        end
        rv = {1'b0, 8'(rexp), 23'(mant)};
        return {1'b0, guard || sticky, rv};
    endfunction

    task automatic launch(input logic [31:0] x);
        @(negedge clk);
        op    = x;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called #1 after the start edge: waits for done and checks everything
    task automatic finish_op(input string tag, input logic [33:0] expv, input logic [31:0] prev);
        int   lat;
        logic held;
        held = (res === prev);
        chk($sformatf("%s_busy", tag), {31'd0, done}, 32'd0);
        lat = 0;
        while (lat < 60 && done !== 1'b1) begin
            @(posedge clk);
            #1;
            lat++;
            if (done !== 1'b1 && res !== prev) held = 1'b0;
        end
        chk($sformatf("%s_lat", tag), 32'(lat), 32'd27);
        chk($sformatf("%s_res", tag), res, expv[31:0]);
        chk($sformatf("%s_exc", tag), {31'd0, exception}, {31'd0, expv[33]});
        chk($sformatf("%s_inx", tag), {31'd0, inexact}, {31'd0, expv[32]});
        chk($sformatf("%s_hold", tag), {31'd0, held}, 32'd1);
        chk($sformatf("%s_ovuf", tag), {31'd0, overflow | underflow}, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [31:0] x, input logic [33:0] expv);
        logic [31:0] prev;
        prev = res;
        launch(x);
        finish_op(tag, expv, prev);
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] prev;
        rst_n = 1'b1;
        start = 1'b0;
        op    = 32'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_res", res, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd1);
        chk("rst_exc", {31'd0, exception}, 32'd0);
        chk("rst_inx", {31'd0, inexact}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed values with hand-derived expectations
        do_op("four",   32'h40800000, {2'b00, 32'h40000000});
        do_op("two",    32'h40000000, {2'b01, 32'h3FB504F3});
        do_op("rne_dn", 32'h3F800001, {2'b01, 32'h3F800000});
        do_op("neg",    32'hC0800000, {2'b10, QNAN});
        do_op("pinf",   32'h7F800000, {2'b00, 32'h7F800000});
        do_op("ninf",   32'hFF800000, {2'b10, QNAN});
        do_op("nzero",  32'h80000000, {2'b00, 32'h80000000});
        do_op("pzero",  32'h00000000, {2'b00, 32'h00000000});
        do_op("snan",   32'h7F800001, {2'b10, QNAN});
        do_op("qnan",   32'hFFC12345, {2'b00, QNAN});
        do_op("nine",   32'h41100000, {2'b00, 32'h40400000});
`ifdef FP_SQRT_SUBNORMAL_EN
        do_op("sub_min", 32'h00000001, {2'b01, 32'h1A3504F3});
`else
        do_op("sub_min", 32'h00000001, {2'b00, 32'h00000000});
        do_op("sub_neg", 32'h80000005, {2'b00, 32'h80000000});
`endif
        do_op("maxnorm", 32'h7F7FFFFF, ref_sqrt(32'h7F7FFFFF));
        do_op("minnorm", 32'h00800000, {2'b00, 32'h20000000});

        // Restart while busy: only the second operand yields a result
        prev = res;
        launch(32'h40800000);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("restart_busy0", {31'd0, done}, 32'd0);
        launch(32'h41100000);
        finish_op("restart", {2'b00, 32'h40400000}, prev);

        // Leave a non-zero inexact result, then reset mid-iteration
        do_op("pre_rst", 32'h40000000, {2'b01, 32'h3FB504F3});
        launch(32'h40800000);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_res", res, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd1);
        chk("midrst_inx", {31'd0, inexact}, 32'd0);
        chk("midrst_exc", {31'd0, exception}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 32'h41100000, {2'b00, 32'h40400000});

        // Randomised operands against the reference model
        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            case (i % 4)
                0: x = x;
                1: x[31] = 1'b0;
                2: begin
                    x[31]    = 1'b0;
                    x[30:23] = 8'd0;
                end
                default: begin
                    x[31]    = 1'b0;
                    x[30:23] = 8'd100 + 8'(i);
                end
            endcase
            do_op($sformatf("rand%0d", i), x, ref_sqrt(x));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
